// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared definitions for the MEM-stage memory access controller: funct3
// encodings of the RV32 loads/stores, FSM state encoding, the parked
// write address and a decode helper that turns funct3 into an access size.
// No ports; imported by mem_access_ctrl and mem_load_ext.

package mem_access_ctrl_pkg;

  // funct3 encodings, shared by loads and stores (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Address shown to the RAM write port while no write is happening, chosen
  // so the RAM's same-address write->read bypass can never hit a real read.
  localparam logic [31:0] PARK_ADDR_DEF = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_e;

  // Unsigned variants only exist for loads; any other code is "no access".
  function automatic size_e decodeSize(input logic isStore, input logic [2:0] f3);
    size_e sz;
    case (f3)
      F3_B:    sz = SZ_BYTE;
      F3_H:    sz = SZ_HALF;
      F3_W:    sz = SZ_WORD;
      F3_BU:   sz = isStore ? SZ_NONE : SZ_BYTE;
      F3_HU:   sz = isStore ? SZ_NONE : SZ_HALF;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// mem_load_ext
// Combinational load extender: picks the byte/halfword addressed by the low
// address bits out of a RAM word and sign- or zero-extends it.
// Ports:
//   funct3_i   in  3       load type (LB/LH/LW/LBU/LHU)
//   byte_off_i in  2       addr[1:0] of the load
//   word_i     in  DATA_W  RAM word
//   data_o     out DATA_W  extended load result

module mem_load_ext
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        byte_off_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane select; halfword lane ignores addr[0] (misaligned halves never reach here)
  always_comb begin
    byteSel = word_i[{byte_off_i, 3'b000} +: 8];
    halfSel = word_i[{byte_off_i[1], 4'b0000} +: 16];
    data_o  = word_i;
    case (funct3_i)
      F3_B:    data_o = {{(DATA_W-8){byteSel[7]}}, byteSel};
      F3_BU:   data_o = {{(DATA_W-8){1'b0}}, byteSel};
      F3_H:    data_o = {{(DATA_W-16){halfSel[15]}}, halfSel};
      F3_HU:   data_o = {{(DATA_W-16){1'b0}}, halfSel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage access controller for a word-wide synchronous-write RAM with a
// combinational read port. Loads and aligned word stores complete in one
// cycle; byte/half stores do a read-modify-write over three cycles
// (IDLE -> RMW_RD -> RMW_WR), stalling the pipeline for the first two.
// Misaligned accesses are flagged and suppressed.
// Ports:
//   clk_100MHz  in   1       clock
//   arst_n      in   1       async active-low reset
//   mem_req_i   in   1       memory instruction valid in MEM
//   mem_we_i    in   1       1=store, 0=load
//   funct3_i    in   3       access type
//   addr_i      in   ADDR_W  byte address
//   wdata_i     in   DATA_W  store data
//   r_ena_o     out  1       RAM read enable
//   r_addr_o    out  ADDR_W  RAM read address (0 when idle)
//   r_data_i    in   DATA_W  RAM read data, same cycle
//   w_ena_o     out  1       RAM write enable
//   w_addr_o    out  ADDR_W  RAM write address (PARK_ADDR when idle)
//   w_data_o    out  DATA_W  RAM write word
//   load_data_o out  DATA_W  extended load result
//   stall_o     out  1       pipeline hold
//   misalign_o  out  1       misaligned access flag

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] PARK_ADDR = ADDR_W'(PARK_ADDR_DEF)
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              r_ena_o,
  output logic [ADDR_W-1:0] r_addr_o,
  input  logic [DATA_W-1:0] r_data_i,
  output logic              w_ena_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [DATA_W-1:0] w_data_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              stall_o,
  output logic              misalign_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] merge_q, merge_d;

  size_e             accSize;
  logic              accLegal;
  logic              accMisaligned;
  logic              reqActive;
  logic [ADDR_W-1:0] wordAddr;
  logic [DATA_W-1:0] extData;
  logic [DATA_W-1:0] laneMerged;

  // Outputs are combinational, so reset has to gate the request directly to
  // keep every output quiet while arst_n is low.
  assign reqActive     = mem_req_i & arst_n;
  assign accSize       = decodeSize(mem_we_i, funct3_i);
  assign accLegal      = (accSize != SZ_NONE);
  assign accMisaligned = ((accSize == SZ_HALF) && addr_i[0]) ||
                         ((accSize == SZ_WORD) && (addr_i[1:0] != 2'b00));
  assign wordAddr      = {addr_i[ADDR_W-1:2], 2'b00};

  mem_load_ext #(
    .DATA_W(DATA_W)
  ) uLoadExt (
    .funct3_i  (funct3_i),
    .byte_off_i(addr_i[1:0]),
    .word_i    (r_data_i),
    .data_o    (extData)
  );

  // The pipeline is held during the RMW, so addr_i/wdata_i are still the
  // store's operands when the new lane is written into the captured word.
  always_comb begin
    laneMerged = merge_q;
    if (accSize == SZ_BYTE) begin
      laneMerged[{addr_i[1:0], 3'b000} +: 8] = wdata_i[7:0];
    end else begin
      laneMerged[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
    end
  end

  // Next state and all outputs. Dropping mem_req_i mid-RMW means the store
  // was squashed, so the FSM abandons it without writing.
  always_comb begin
    state_d     = state_q;
    merge_d     = merge_q;
    r_ena_o     = 1'b0;
    r_addr_o    = '0;
    w_ena_o     = 1'b0;
    w_addr_o    = PARK_ADDR;
    w_data_o    = '0;
    load_data_o = '0;
    stall_o     = 1'b0;
    misalign_o  = 1'b0;
    if (!reqActive) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accLegal && accMisaligned) begin
            misalign_o = 1'b1;
          end else if (accLegal && !mem_we_i) begin
            r_ena_o     = 1'b1;
            r_addr_o    = wordAddr;
            load_data_o = extData;
          end else if (accLegal && (accSize == SZ_WORD)) begin
            w_ena_o  = 1'b1;
            w_addr_o = wordAddr;
            w_data_o = wdata_i;
          end else if (accLegal) begin
            stall_o  = 1'b1;
            r_ena_o  = 1'b1;
            r_addr_o = wordAddr;
            merge_d  = r_data_i;
            state_d  = RMW_RD;
          end
        end
        RMW_RD: begin
          stall_o = 1'b1;
          merge_d = laneMerged;
          state_d = RMW_WR;
        end
        RMW_WR: begin
          w_ena_o  = 1'b1;
          w_addr_o = wordAddr;
          w_data_o = merge_q;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and merge buffer; reset discards any half-finished RMW.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. A 16-word RAM model answers the
// DUT's read/write ports; a separate reference memory plus per-instruction
// cycle expectations predict every output, and a compare process checks them
// on every falling edge. Directed scenarios pin known values, then random
// loads/stores/idles run against the reference.

module tb_mem_access_ctrl;

  logic        clk_100MHz;
  logic        arst_n;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        r_ena_o;
  logic [31:0] r_addr_o;
  logic [31:0] r_data_i;
  logic        w_ena_o;
  logic [31:0] w_addr_o;
  logic [31:0] w_data_o;
  logic [31:0] load_data_o;
  logic        stall_o;
  logic        misalign_o;

  logic [31:0] ram[16];
  logic [31:0] refMem[16];
  int          writeCount;
  int          expWrites;

  logic        expStall, expREna, expWEna, expMis, expCheckLoad;
  logic [31:0] expRAddr, expWAddr, expWData, expLoad;

  int          checks;
  int          failures;
  int          stallSeen;
  logic [31:0] lastLoad;
  logic [31:0] lastWData;
  logic        lastMis;

  bit          rWe;
  bit [2:0]    rF3;
  logic [31:0] rAddr;
  logic [31:0] rData;
  int          rDrop;

  mem_access_ctrl uDut (
    .clk_100MHz (clk_100MHz),
    .arst_n     (arst_n),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .funct3_i   (funct3_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .r_ena_o    (r_ena_o),
    .r_addr_o   (r_addr_o),
    .r_data_i   (r_data_i),
    .w_ena_o    (w_ena_o),
    .w_addr_o   (w_addr_o),
    .w_data_o   (w_data_o),
    .load_data_o(load_data_o),
    .stall_o    (stall_o),
    .misalign_o (misalign_o)
  );

  // 100 MHz clock
  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  // RAM environment: combinational read, write on the rising edge
  assign r_data_i = ram[r_addr_o[5:2]];

  always @(posedge clk_100MHz) begin
    if (w_ena_o) begin
      writeCount <= writeCount + 1;
      if (w_addr_o < 32'd64) ram[w_addr_o[5:2]] <= w_data_o;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, actual, expected);
    end
  endtask

  // Reference load result from the word, offset and load type
  function automatic logic [31:0] modelLoad(input bit [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] v;
    if (f3[1:0] == 2'd0) begin
      v = (w >> (8 * off)) & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3[1:0] == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Reference sub-word store: replace one byte/half lane of the old word
  function automatic logic [31:0] modelMerge(input logic [31:0] w, input logic [31:0] d, input int size, input int off);
    int          sh;
    logic [31:0] mask;
    sh   = (size == 0) ? 8 * off : 16 * (off / 2);
    mask = ((size == 0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // No access: everything quiet, write address parked
  task automatic setQuietExp(input logic checkLoad);
    expStall     = 1'b0;
    expREna      = 1'b0;
    expRAddr     = 32'h0;
    expWEna      = 1'b0;
    expWAddr     = 32'hFFFF_FFFC;
    expWData     = 32'h0;
    expLoad      = 32'h0;
    expMis       = 1'b0;
    expCheckLoad = checkLoad;
  endtask

  // Single compare process against the expectations of the current cycle
  always @(negedge clk_100MHz) begin
    checkOutput("stall_o", {31'b0, stall_o}, {31'b0, expStall});
    checkOutput("r_ena_o", {31'b0, r_ena_o}, {31'b0, expREna});
    checkOutput("r_addr_o", r_addr_o, expRAddr);
    checkOutput("w_ena_o", {31'b0, w_ena_o}, {31'b0, expWEna});
    checkOutput("w_addr_o", w_addr_o, expWAddr);
    checkOutput("misalign_o", {31'b0, misalign_o}, {31'b0, expMis});
    if (expWEna) checkOutput("w_data_o", w_data_o, expWData);
    if (expCheckLoad) checkOutput("load_data_o", load_data_o, expLoad);
  end

  task automatic sampleCycle();
    @(negedge clk_100MHz);
    #1;
    stallSeen = stallSeen + (stall_o ? 1 : 0);
    lastLoad  = load_data_o;
    lastMis   = misalign_o;
    if (w_ena_o) lastWData = w_data_o;
  endtask

  task automatic idleCycle();
    @(posedge clk_100MHz);
    #1;
    mem_req_i = 1'b0;
    mem_we_i  = 1'($urandom);
    funct3_i  = 3'($urandom);
    addr_i    = $urandom;
    wdata_i   = $urandom;
    setQuietExp(1'b1);
    sampleCycle();
  endtask

  // One memory instruction; dropAt=1/2 squashes a sub-word store in that cycle
  task automatic applyStimulus(input bit we, input bit [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata, input int dropAt);
    bit          legal, mis;
    int          size, idx;
    logic [31:0] wordAddr, merged;
    legal    = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size     = int'(f3[1:0]);
    mis      = legal && ((size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00));
    wordAddr = {addr[31:2], 2'b00};
    idx      = int'(addr[5:2]);
    stallSeen = 0;
    @(posedge clk_100MHz);
    #1;
    mem_req_i = 1'b1;
    mem_we_i  = we;
    funct3_i  = f3;
    addr_i    = addr;
    wdata_i   = wdata;
    setQuietExp(1'b1);
    if (!legal || mis) begin
      expMis       = mis;
      expCheckLoad = 1'b0;
      sampleCycle();
    end else if (!we) begin
      expREna  = 1'b1;
      expRAddr = wordAddr;
      expLoad  = modelLoad(f3, int'(addr[1:0]), refMem[idx]);
      sampleCycle();
    end else if (size == 2) begin
      expCheckLoad = 1'b0;
      expWEna      = 1'b1;
      expWAddr     = wordAddr;
      expWData     = wdata;
      refMem[idx]  = wdata;
      expWrites++;
      sampleCycle();
    end else begin
      expCheckLoad = 1'b0;
      expStall     = 1'b1;
      expREna      = 1'b1;
      expRAddr     = wordAddr;
      merged       = modelMerge(refMem[idx], wdata, size, int'(addr[1:0]));
      sampleCycle();
      for (int c = 1; c <= 2; c++) begin
        @(posedge clk_100MHz);
        #1;
        setQuietExp(1'b0);
        if (dropAt == c) begin
          mem_req_i = 1'b0;
          sampleCycle();
          break;
        end
        if (c == 1) begin
          expStall = 1'b1;
        end else begin
          expWEna     = 1'b1;
          expWAddr    = wordAddr;
          expWData    = merged;
          refMem[idx] = merged;
          expWrites++;
        end
        sampleCycle();
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    writeCount = 0;
    expWrites  = 0;
    lastLoad   = 32'h0;
    lastWData  = 32'h0;
    lastMis    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ram[i]    = $urandom;
      refMem[i] = ram[i];
    end
    ram[4]    = 32'h8765_4321;
    refMem[4] = 32'h8765_4321;

    // Reset held with a live load request: outputs must stay quiet
    arst_n    = 1'b0;
    mem_req_i = 1'b1;
    mem_we_i  = 1'b0;
    funct3_i  = 3'b010;
    addr_i    = 32'h10;
    wdata_i   = 32'h0;
    setQuietExp(1'b1);
    repeat (2) @(negedge clk_100MHz);
    @(posedge clk_100MHz);
    #1;
    arst_n    = 1'b1;
    mem_req_i = 1'b0;
    sampleCycle();

    // Load extraction on 0x8765_4321 @0x10
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 0);
    checkOutput("LB_0x13", lastLoad, 32'hFFFF_FF87);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 0);
    checkOutput("LBU_0x13", lastLoad, 32'h0000_0087);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 0);
    checkOutput("LH_0x12", lastLoad, 32'hFFFF_8765);

    // SB read-modify-write
    applyStimulus(1'b1, 3'b000, 32'h11, 32'h0000_00AB, 0);
    checkOutput("SB_stall_cycles", stallSeen, 2);
    checkOutput("SB_w_data", lastWData, 32'h8765_AB21);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0);
    checkOutput("LW_after_SB", lastLoad, 32'h8765_AB21);

    // Aligned SW
    applyStimulus(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 0);
    checkOutput("SW_stall_cycles", stallSeen, 0);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 0);
    checkOutput("LW_after_SW", lastLoad, 32'hDEAD_BEEF);

    // Misaligned accesses
    applyStimulus(1'b0, 3'b010, 32'h22, 32'h0, 0);
    checkOutput("LW_0x22_mis", {31'b0, lastMis}, 32'h1);
    applyStimulus(1'b1, 3'b001, 32'h21, 32'h1234_5678, 0);
    checkOutput("SH_0x21_mis", {31'b0, lastMis}, 32'h1);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 0);
    checkOutput("LW_0x20_unchanged", lastLoad, 32'hDEAD_BEEF);

    // SH squashed in RMW_RD, then a load must see an idle FSM
    applyStimulus(1'b1, 3'b001, 32'h14, 32'h0000_5A5A, 1);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 0);
    checkOutput("SH_abort_no_stall", stallSeen, 0);
    idleCycle();
    checkOutput("writes_directed", writeCount, expWrites);

    // Reset pulsed while the FSM sits in RMW_RD
    @(posedge clk_100MHz);
    #1;
    mem_req_i = 1'b1;
    mem_we_i  = 1'b1;
    funct3_i  = 3'b001;
    addr_i    = 32'h14;
    wdata_i   = 32'h0000_C3C3;
    setQuietExp(1'b0);
    expStall = 1'b1;
    expREna  = 1'b1;
    expRAddr = 32'h14;
    sampleCycle();
    @(posedge clk_100MHz);
    #1;
    setQuietExp(1'b0);
    expStall = 1'b1;
    sampleCycle();
    #1;
    arst_n = 1'b0;
    setQuietExp(1'b1);
    #1;
    checkOutput("rst_stall", {31'b0, stall_o}, 32'h0);
    checkOutput("rst_w_ena", {31'b0, w_ena_o}, 32'h0);
    checkOutput("rst_r_ena", {31'b0, r_ena_o}, 32'h0);
    checkOutput("rst_w_addr", w_addr_o, 32'hFFFF_FFFC);
    checkOutput("rst_load", load_data_o, 32'h0);
    sampleCycle();
    @(posedge clk_100MHz);
    #1;
    arst_n    = 1'b1;
    mem_req_i = 1'b0;
    setQuietExp(1'b1);
    sampleCycle();
    idleCycle();
    checkOutput("writes_after_reset", writeCount, expWrites);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 0);

    // Randomized traffic against the reference memory
    for (int n = 0; n < 400; n++) begin
      rWe   = 1'($urandom_range(0, 1));
      rF3   = 3'($urandom_range(0, 7));
      rAddr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) rAddr[1:0] = 2'b00;
      rData = $urandom;
      rDrop = (rWe && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      applyStimulus(rWe, rF3, rAddr, rData, rDrop);
      if ($urandom_range(0, 3) == 0) idleCycle();
    end

    idleCycle();
    checkOutput("writes_total", writeCount, expWrites);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("ram_word_%0d", i), ram[i], refMem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, data word width; the RAM word and all data ports use this width.
REQ-002 Parameter: ADDR_W, 32, byte address width.
REQ-003 Parameter: PARK_ADDR, 32'hFFFF_FFFC, value driven on w_addr_o whenever w_ena_o=0.
REQ-004 Clock and reset: clk_100MHz is the clock; arst_n is the reset, asynchronous, active-low.
REQ-005 Ports, one per line: name, direction, width, meaning.
- clk_100MHz  in  1  clock.
- arst_n  in  1  async active-low reset.
- mem_req_i  in  1  MEM-stage memory instruction valid.
- mem_we_i  in  1  1=store, 0=load.
- funct3_i  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  DATA_W  store data (rs2).
- r_ena_o  out  1  RAM read enable.
- r_addr_o  out  ADDR_W  RAM read address.
- r_data_i  in  DATA_W  RAM read data, combinational, same cycle.
- w_ena_o  out  1  RAM write enable.
- w_addr_o  out  ADDR_W  RAM write address.
- w_data_o  out  DATA_W  RAM write word.
- load_data_o  out  DATA_W  extended load result to the WB path.
- stall_o  out  1  holds IF/ID/EX/MEM registers.
- misalign_o  out  1  misaligned-access flag.

Function
REQ-006 The FSM SHALL have three states: IDLE, RMW_RD, RMW_WR.
REQ-007 A load in IDLE SHALL drive r_ena_o=1 and r_addr_o={addr_i[31:2],2'b00} with zero stall.
REQ-008 load_data_o SHALL be valid in the same cycle as the load.
REQ-009 Load extraction: LB/LBU select byte addr_i[1:0]; LH/LHU select half addr_i[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-010 An aligned SW in IDLE SHALL drive w_ena_o=1, w_addr_o=word address and w_data_o=wdata_i in the same cycle, with no stall; the write commits at the next edge.
REQ-011 SB/SH in IDLE SHALL assert stall_o=1 and r_ena_o=1 at the word address, capture r_data_i into merge_q at the edge, and transition IDLE->RMW_RD->RMW_WR.
REQ-012 In RMW_RD, stall_o SHALL be 1, there SHALL be no RAM access, and merge_q SHALL be overwritten with the target byte (wdata_i[7:0]) or half (wdata_i[15:0]) at its lane.
REQ-013 In RMW_WR, stall_o SHALL be 0 and w_ena_o=1 with w_data_o=merge_q; the state returns to IDLE at the edge.
REQ-014 Sub-word store latency SHALL be 3 cycles, including 2 stall cycles.
REQ-015 Misalignment SHALL be defined as LH/LHU/SH with addr_i[0]=1, or LW/SW with addr_i[1:0]!=0.
REQ-016 A misaligned access SHALL set misalign_o=1 combinationally, with no RAM enable, no stall, and no state change.
REQ-017 When w_ena_o=0, w_addr_o SHALL equal PARK_ADDR so the RAM same-address bypass never aliases a read.
REQ-018 When r_ena_o=0, r_addr_o SHALL equal 0.
REQ-019 If mem_req_i=0 in RMW_RD or RMW_WR, the FSM SHALL abort to IDLE with no write and stall_o=0.
REQ-020 When mem_req_i=0 in IDLE, all RAM enables, stall_o and misalign_o SHALL be 0, and load_data_o SHALL be 0.
REQ-021 funct3 codes outside the defined set SHALL be treated as no access, with misalign_o=0.

Reset
REQ-022 While arst_n=0, the state SHALL be IDLE and merge_q=0.
REQ-023 While arst_n=0, stall_o, r_ena_o, w_ena_o, misalign_o and load_data_o SHALL be 0, and w_addr_o SHALL equal PARK_ADDR.
REQ-024 Reset asserted mid-RMW SHALL drop the pending store with no partial write.

Structure
REQ-025 The funct3 codes, the FSM state encodings and PARK_ADDR SHALL reside in the shared define header.
REQ-026 The load extender SHALL be a combinational sub-module named mem_load_ext.

Verification
REQ-027 Scenario: RAM word 0x8765_4321 @0x10; LB 0x13 -> 0xFFFF_FF87; LBU 0x13 -> 0x0000_0087; LH 0x12 -> 0xFFFF_8765.
REQ-028 Scenario: SB 0x11 with wdata 0xAB over 0x8765_4321 -> stall 2 cycles, w_data_o=0x8765_AB21 in cycle 3, then LW 0x10 -> 0x8765_AB21.
REQ-029 Scenario: SW 0x20 with wdata 0xDEAD_BEEF -> w_ena_o same cycle, stall_o=0, then LW 0x20 -> 0xDEAD_BEEF.
REQ-030 Scenario: LW 0x22 / SH 0x21 -> misalign_o=1, no enables, RAM unchanged.
REQ-031 Scenario: SH 0x14, mem_req_i dropped in RMW_RD -> no write, IDLE next cycle.
REQ-032 Scenario: arst_n pulsed low in RMW_RD -> outputs reset immediately, no write, and w_addr_o=0xFFFF_FFFC.
